// File: rtl/adc_ltc2308_ctrl.sv
// SPI master for the LTC2308: pulses CONVST, shifts the 6-bit config out on SDI while
// capturing the 12-bit result on SDO, and tags each sample with the config it was converted under.
module adc_ltc2308_ctrl #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic [5:0]  cfg,
  output logic        busy,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [5:0]  sample_cfg,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  localparam logic [5:0] DEF_CFG = 6'b100010;

  localparam int unsigned MAX_A   = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > CLK_DIV) ? MAX_A : CLK_DIV;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    GAP   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [5:0]       shift_cfg;
  logic [5:0]       cfg_sr;
  logic [5:0]       cur_cfg;
  logic [5:0]       next_cfg;
  logic [11:0]      data_sr;

  // adc_sck doubles as the SCK phase flag inside SHIFT; next_cfg tracks the ADC's pipelined config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift_cfg    <= '0;
      cfg_sr       <= '0;
      cur_cfg      <= DEF_CFG;
      next_cfg     <= DEF_CFG;
      data_sr      <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_cfg   <= DEF_CFG;
      adc_convst   <= 1'b0;
      adc_sck      <= 1'b0;
      adc_sdi      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start || auto_en) begin
            shift_cfg  <= cfg;
            cur_cfg    <= next_cfg;
            cnt        <= '0;
            busy       <= 1'b1;
            adc_convst <= 1'b1;
            state      <= CONV;
          end
        end

        CONV: begin
          if (cnt == CONV_LAST) begin
            cnt        <= '0;
            adc_convst <= 1'b0;
            state      <= GAP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            adc_sdi <= shift_cfg[5];
            cfg_sr  <= {shift_cfg[4:0], 1'b0};
            state   <= SHIFT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            cnt <= '0;
            if (!adc_sck) begin
              // Rising SCK edge: the ADC's SDO bit is stable here.
              adc_sck <= 1'b1;
              data_sr <= {data_sr[10:0], adc_sdo};
            end else begin
              adc_sck <= 1'b0;
              if (bit_idx == 4'd11) begin
                adc_sdi      <= 1'b0;
                sample_valid <= 1'b1;
                sample_data  <= data_sr;
                sample_cfg   <= cur_cfg;
                next_cfg     <= shift_cfg;
                state        <= DONE;
              end else begin
                bit_idx <= bit_idx + 4'd1;
                adc_sdi <= cfg_sr[5];
                cfg_sr  <= {cfg_sr[4:0], 1'b0};
              end
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Scoreboard bench for adc_ltc2308_ctrl: a default-parameter instance and a fast instance
// (CLK_DIV=1, CONV_CYCLES=4, GAP_CYCLES=1), each driven against a behavioural LTC2308 model.
module tb_adc_ltc2308_ctrl;

  localparam logic [5:0] DEF_CFG = 6'b100010;

  typedef struct {
    logic [11:0] data;
    logic [5:0]  cfg;
    logic [5:0]  sent;
    int          t_acc;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic        start        [2];
  logic        auto_en      [2];
  logic [5:0]  cfg          [2];
  logic        busy         [2];
  logic        sample_valid [2];
  logic [11:0] sample_data  [2];
  logic [5:0]  sample_cfg   [2];
  logic        adc_convst   [2];
  logic        adc_sck      [2];
  logic        adc_sdi      [2];
  logic        adc_sdo      [2];

  int lat   [2] = '{131, 30};
  int conv  [2] = '{80, 4};
  int div   [2] = '{2, 1};

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  entry_t      sb    [2][$];
  logic [11:0] codes [2][$];
  logic [5:0]  model_cfg [2];
  int          idle_at   [2];

  adc_ltc2308_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start[0]), .auto_en(auto_en[0]), .cfg(cfg[0]),
    .busy(busy[0]), .sample_valid(sample_valid[0]), .sample_data(sample_data[0]),
    .sample_cfg(sample_cfg[0]), .adc_convst(adc_convst[0]), .adc_sck(adc_sck[0]),
    .adc_sdi(adc_sdi[0]), .adc_sdo(adc_sdo[0])
  );

  adc_ltc2308_ctrl #(.CLK_DIV(1), .CONV_CYCLES(4), .GAP_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst), .start(start[1]), .auto_en(auto_en[1]), .cfg(cfg[1]),
    .busy(busy[1]), .sample_valid(sample_valid[1]), .sample_data(sample_data[1]),
    .sample_cfg(sample_cfg[1]), .adc_convst(adc_convst[1]), .adc_sck(adc_sck[1]),
    .adc_sdi(adc_sdi[1]), .adc_sdo(adc_sdo[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_chk
    // ADC model: a new code is loaded at CONVST and shifted out MSB first, one bit per rising SCK.
    logic [11:0] sh = 12'h000;
    always @(posedge adc_convst[g] or posedge adc_sck[g]) begin
      if (adc_convst[g]) sh = (codes[g].size() > 0) ? codes[g].pop_front() : 12'h000;
      else               sh = {sh[10:0], 1'b0};
    end
    assign adc_sdo[g] = sh[11];

    // Monitor: pops the expected sample whenever sample_valid is seen.
    int          conv_hi, sck_hi, nrise;
    logic [11:0] sdi_bits;
    logic        sck_q, proto_bad, busy_chk;
    entry_t      e;
    always @(negedge clk) begin
      if (rst) begin
        conv_hi = 0; sck_hi = 0; nrise = 0; sdi_bits = '0;
        sck_q = 1'b0; proto_bad = 1'b0; busy_chk = 1'b0;
      end else begin
        if (busy_chk) check($sformatf("u%0d_busy_after_done", g), 32'(busy[g]), 0);
        busy_chk = 1'b0;
        if (adc_convst[g]) conv_hi++;
        if (adc_sck[g]) sck_hi++;
        if (adc_sck[g] && !sck_q) begin
          sdi_bits = {sdi_bits[10:0], adc_sdi[g]};
          nrise++;
        end
        sck_q = adc_sck[g];
        if (!busy[g] && (adc_convst[g] || adc_sck[g] || adc_sdi[g] || sample_valid[g]))
          proto_bad = 1'b1;
        if (sample_valid[g]) begin
          if (sb[g].size() == 0) begin
            check($sformatf("u%0d_unexpected_valid", g), 1, 0);
          end else begin
            e = sb[g].pop_front();
            check($sformatf("u%0d_data", g), 32'(sample_data[g]), 32'(e.data));
            check($sformatf("u%0d_cfg", g), 32'(sample_cfg[g]), 32'(e.cfg));
            check($sformatf("u%0d_valid_cycle", g), cyc, e.t_acc + lat[g]);
            check($sformatf("u%0d_convst_cycles", g), conv_hi, conv[g]);
            check($sformatf("u%0d_sck_high_cycles", g), sck_hi, 12 * div[g]);
            check($sformatf("u%0d_sck_pulses", g), nrise, 12);
            check($sformatf("u%0d_sdi_seq", g), 32'(sdi_bits), 32'({e.sent, 6'b000000}));
            check($sformatf("u%0d_protocol", g), 32'(proto_bad), 0);
          end
          conv_hi = 0; sck_hi = 0; nrise = 0; sdi_bits = '0; proto_bad = 1'b0;
          busy_chk = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  // Reference model: a request is taken only when the unit is idle; the sample reports the
  // config shifted during the previous accepted transaction.
  task automatic model_accept(input int g, input logic [5:0] c, input logic [11:0] code);
    entry_t ne;
    if (cyc >= idle_at[g]) begin
      ne.data  = code;
      ne.cfg   = model_cfg[g];
      ne.sent  = c;
      ne.t_acc = cyc;
      sb[g].push_back(ne);
      codes[g].push_back(code);
      model_cfg[g] = c;
      idle_at[g]   = cyc + lat[g] + 1;
    end
  endtask

  task automatic pulse(input int g, input logic [5:0] c, input logic [11:0] code);
    start[g] = 1'b1;
    cfg[g]   = c;
    model_accept(g, c, code);
    tick(1);
    start[g] = 1'b0;
    cfg[g]   = 6'($urandom);
  endtask

  task automatic auto_run(input int g, input logic [11:0] c0, input logic [11:0] c1,
                          input logic [11:0] c2);
    logic [11:0] cs [3];
    cs = '{c0, c1, c2};
    wait_until(idle_at[g]);
    auto_en[g] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_until(idle_at[g]);
      cfg[g] = 6'($urandom);
      model_accept(g, cfg[g], cs[i]);
      tick(1);
    end
    tick(20);
    auto_en[g] = 1'b0;
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      sb[g].delete();
      codes[g].delete();
      model_cfg[g] = DEF_CFG;
      idle_at[g]   = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int t;
    int g;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; auto_en[i] = 1'b0; cfg[i] = 6'b000000;
    end
    model_reset();
    tick(3);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 0);
      check($sformatf("u%0d_rst_valid", i), 32'(sample_valid[i]), 0);
      check($sformatf("u%0d_rst_data", i), 32'(sample_data[i]), 0);
      check($sformatf("u%0d_rst_cfg", i), 32'(sample_cfg[i]), 32'(DEF_CFG));
      check($sformatf("u%0d_rst_pins", i), 32'({adc_convst[i], adc_sck[i], adc_sdi[i]}), 0);
    end
    rst = 1'b0;
    tick(2);

    // First transaction with two starts dropped while busy; fast instance runs alongside.
    t = cyc;
    pulse(0, 6'b110010, 12'hA5C);
    pulse(1, 6'b011011, 12'h3C3);
    wait_until(t + 10);
    pulse(0, 6'($urandom), 12'($urandom));
    wait_until(t + 100);
    pulse(0, 6'($urandom), 12'($urandom));

    // Second transaction reports the pipelined config of the first.
    wait_until(idle_at[0]);
    pulse(0, 6'b100010, 12'h001);
    wait_until(idle_at[1]);
    pulse(1, 6'b100110, 12'h3C3);

    auto_run(0, 12'hFFF, 12'h000, 12'h800);
    auto_run(1, 12'h123, 12'hFED, 12'h555);

    // Randomized transactions with extra starts issued mid-flight.
    for (int i = 0; i < 8; i++) begin
      g = i % 2;
      wait_until(idle_at[g] + int'($urandom_range(0, 3)));
      pulse(g, 6'($urandom), 12'($urandom));
      tick(int'($urandom_range(2, 20)));
      pulse(g, 6'($urandom), 12'($urandom));
    end

    // Reset during SHIFT bit 5 (SCK high phase), then the config restarts at the default.
    wait_until(idle_at[0] > idle_at[1] ? idle_at[0] : idle_at[1]);
    t = cyc;
    pulse(0, 6'b010101, 12'h777);
    wait_until(t + 105);
    check("u0_pre_rst_sck", 32'(adc_sck[0]), 1);
    rst = 1'b1;
    #1;
    check("u0_abort_sck", 32'(adc_sck[0]), 0);
    check("u0_abort_convst", 32'(adc_convst[0]), 0);
    check("u0_abort_busy", 32'(busy[0]), 0);
    check("u0_abort_valid", 32'(sample_valid[0]), 0);
    model_reset();
    tick(2);
    rst = 1'b0;
    tick(1);
    pulse(0, 6'($urandom), 12'($urandom));
    pulse(1, 6'($urandom), 12'($urandom));

    wait_until((idle_at[0] > idle_at[1] ? idle_at[0] : idle_at[1]) + 10);
    check("u0_sb_drained", sb[0].size(), 0);
    check("u1_sb_drained", sb[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
